// File: rtl/display_mux_7seg_if.sv
// rtl/display_mux_7seg_if.sv - segment/anode bus between pattern source and 7-seg scan driver
interface display_mux_7seg_if #(
    parameter int N_DIGITS = 4
);
    logic [7*N_DIGITS-1:0] seg_in;
    logic [N_DIGITS-1:0]   digit_en;
    logic [6:0]            seg;
    logic [N_DIGITS-1:0]   an;
    logic                  frame_start;

    modport master (
        output seg_in, digit_en,
        input  seg, an, frame_start
    );

    modport slave (
        input  seg_in, digit_en,
        output seg, an, frame_start
    );
endinterface

// File: rtl/display_mux_7seg.sv
// rtl/display_mux_7seg.sv - time-multiplexed common-anode 7-seg scan driver with blanking and per-frame capture
module display_mux_7seg #(
    parameter int N_DIGITS     = 4,
    parameter int REFRESH_DIV  = 27000,
    parameter int BLANK_CYCLES = 270
) (
    input  logic                  clk,
    input  logic                  rst_n,
    display_mux_7seg_if.slave     bus
);
    localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int IW = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;

    logic [CW-1:0]           cnt, cnt_nxt;
    logic [IW-1:0]           idx, idx_nxt;
    logic [7*N_DIGITS-1:0]   shadow_seg;
    logic [N_DIGITS-1:0]     shadow_en;
    logic                    capture, drive;
    logic [N_DIGITS-1:0]     an_nxt, an_q;
    logic [6:0]              seg_nxt, seg_q;
    logic                    frame_start_q;

    assign bus.an          = an_q;
    assign bus.seg         = seg_q;
    assign bus.frame_start = frame_start_q;

    always_comb begin
        capture = (cnt == '0) && (idx == '0);
        drive   = (cnt >= CW'(BLANK_CYCLES));
        if (cnt == CW'(REFRESH_DIV - 1)) begin
            cnt_nxt = '0;
            idx_nxt = (idx == IW'(N_DIGITS - 1)) ? '0 : idx + 1'b1;
        end else begin
            cnt_nxt = cnt + 1'b1;
            idx_nxt = idx;
        end
    end

    // Capture happens only at cnt==0, which is always blank, so the current
    // shadow contents are safe to drive from without a bypass.
    always_comb begin
        an_nxt  = '1;
        seg_nxt = 7'h7f;
        for (int k = 0; k < N_DIGITS; k++) begin
            if (drive && (IW'(k) == idx) && shadow_en[k]) begin
                an_nxt[k] = 1'b0;
                seg_nxt   = shadow_seg[7*k +: 7];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt           <= '0;
            idx           <= '0;
            shadow_seg    <= '1;
            shadow_en     <= '0;
            an_q          <= '1;
            seg_q         <= 7'h7f;
            frame_start_q <= 1'b0;
        end else begin
            cnt           <= cnt_nxt;
            idx           <= idx_nxt;
            frame_start_q <= capture;
            an_q          <= an_nxt;
            seg_q         <= seg_nxt;
            if (capture) begin
                shadow_seg <= bus.seg_in;
                shadow_en  <= bus.digit_en;
            end
        end
    end
endmodule
